vga_write_buffer: RTL and testbench
===================================

Name: vga_write_buffer

Overview:
- Posted-write buffer between the CPU's video-memory write path (WVM instruction) and the 3-bit video RAM write port.
- Queues {address, colour} writes from the CPU in a small FIFO.
- Commits queued writes only while the VGA scan is in blanking, so framebuffer updates never land mid-visible-line.
- Tells the CPU when the buffer is full and flags lost writes.

Parameters:
- COLOR_W, 3: colour width per cell.
- ADDR_W, 10: video RAM address width, {row[8:4], col[9:5]}.
- DEPTH_LOG2, 3: FIFO depth = 2**DEPTH_LOG2 (8 entries).
- H_VISIBLE, 640: first non-visible column count.
- V_VISIBLE, 480: first non-visible row count.

Ports:
- Clock, input, 1: system clock; all state on rising edge.
- Reset, input, 1: asynchronous, active-high reset.
- iWriteEnable, input, 1: CPU write request, one entry per cycle high.
- iWriteAddress, input, ADDR_W: CPU target cell.
- iDataIn, input, COLOR_W: CPU colour.
- iColumnCount, input, 10: VGA controller column counter.
- iRowCount, input, 10: VGA controller row counter.
- oFull, output, 1: FIFO holds 2**DEPTH_LOG2 entries.
- oPending, output, DEPTH_LOG2+1: current entry count.
- oOverflow, output, 1: sticky, a write was dropped.
- oMemWriteEnable, output, 1: video RAM write enable.
- oMemWriteAddress, output, ADDR_W: video RAM write address.
- oMemDataIn, output, COLOR_W: video RAM write data.

Behaviour:
- Reset (asynchronous, immediate) forces the following:
  - FIFO pointers and count to 0; oPending=0, oFull=0, oOverflow=0.
  - oMemWriteEnable=0, oMemWriteAddress=0, oMemDataIn=0.
  - State=IDLE.
  - Reset mid-drain discards every queued entry. No write pulse may follow reset release until new pushes arrive.
- Blanking (combinational): blank = (iColumnCount >= H_VISIBLE) || (iRowCount >= V_VISIBLE).
- Push: at a rising edge with iWriteEnable=1 and either count<DEPTH or a pop in the same cycle, enqueue {iWriteAddress, iDataIn} at the tail.
- Push when full with no pop: entry dropped, count unchanged, oOverflow<=1. oOverflow clears only on Reset.
- Pop condition: state DRAIN && blank && count>0. The head is removed at that edge.
- Output stage is registered:
  - The edge that pops loads oMemWriteAddress/oMemDataIn with the head entry and sets oMemWriteEnable<=1.
  - Any edge without a pop sets oMemWriteEnable<=0.
  - Address and data hold their last value when not writing.
- FSM:
  - IDLE -> DRAIN at an edge where blank && count>0.
  - DRAIN -> IDLE at an edge where !blank, or where count becomes 0 after that edge's pop/push.
  - DRAIN stays while blank && post-edge count>0.
  - Pops happen only in DRAIN, never on the IDLE->DRAIN edge.
- Latency:
  - Minimum push-to-oMemWriteEnable is 2 edges when already in blanking and empty: push edge, IDLE->DRAIN edge, then the pop edge gives oMemWriteEnable=1 after the 3rd edge.
  - Strictly: push at edge N, state DRAIN at N+1, write pulse visible after N+2.
- Throughput: one write per cycle during blanking.
- Visible-edge guard: a pop may occur on the last blank cycle, so at most one write pulse is presented on the first visible cycle. This is permitted because the RAM write port is independent of the read port.
- Simultaneous push and pop: count unchanged. Full + pop + push is accepted with no overflow.
- Empty + push + pop-condition: the pop condition is false (count=0), so the entry is queued normally.
- Ordering: strict FIFO. Pointers wrap modulo 2**DEPTH_LOG2.
- Count arithmetic is DEPTH_LOG2+1 bits. oFull = (count == 2**DEPTH_LOG2).

Optional Feature:
- Macro: VGA_WB_COALESCE_EN.
- Defined:
  - A push whose iWriteAddress equals the address of the most recently pushed entry still in the FIFO overwrites that entry's colour instead of enqueuing.
  - Count is unchanged and no overflow is raised even if full.
  - This does not apply if that entry is being popped in the same cycle; the push then enqueues normally.
- Undefined: every accepted push enqueues a new entry.

Decomposition:
- Package vga_wb_pkg holds:
  - COLOR_W/ADDR_W defaults.
  - H_VISIBLE/V_VISIBLE constants.
  - FSM state encoding (IDLE=0, DRAIN=1).
  - Entry type {addr, colour}.
- Sub-module vga_wb_fifo: synchronous FIFO with async reset. Ports: push, pop, data in/out, count, full, empty, last-written index (for coalescing).

Test Plan:
- Reset then idle: Reset=1 asynchronously mid-cycle -> all outputs 0 immediately. After release, no oMemWriteEnable for 100 cycles.
- Visible-region queueing: column=100,row=50, push (addr 0x005, col 3'b101) -> oPending=1, oMemWriteEnable stays 0. Column steps to 640 -> exactly one pulse addr 0x005 data 3'b101, 2 edges after blank; oPending=0.
- Fill and overflow: 9 pushes (addrs 0..8) during visible -> oFull=1 after the 8th, oOverflow=1 after the 9th. Blanking then yields 8 consecutive writes addr 0..7 in order; addr 8 never appears.
- Full push+pop: FIFO full in DRAIN/blank with push addr 0x3FF -> accepted, oOverflow stays 0, 0x3FF written last.
- Drain interrupted: 8 queued, blank for 3 cycles -> DRAIN entered then 2 writes (addr 0,1). Remaining 6 written in order at the next blanking.
- Coalesce (VGA_WB_COALESCE_EN): push addr 0x010 colour 1, then addr 0x010 colour 6, during visible -> oPending=1, single write of colour 6. Without the macro: oPending=2, writes colour 1 then 6.

Source files
------------

// File: rtl/vga_wb_pkg.sv
// Shared constants, FSM encoding and entry type for the VGA posted-write buffer.
// Build option VGA_WB_COALESCE_EN is consumed by vga_write_buffer.sv.
package vga_wb_pkg;

    localparam int DEFAULT_COLOR_W    = 3;
    localparam int DEFAULT_ADDR_W     = 10;
    localparam int DEFAULT_DEPTH_LOG2 = 3;
    localparam int SCAN_COUNT_W       = 10;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned V_VISIBLE = 480;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } wbState_t;

    typedef struct packed {
        logic [DEFAULT_ADDR_W-1:0]  addr;
        logic [DEFAULT_COLOR_W-1:0] colour;
    } wbEntry_t;

    // True outside the visible raster, i.e. whenever a framebuffer write cannot tear a line.
    function automatic logic inBlanking(
        input logic [SCAN_COUNT_W-1:0] column,
        input logic [SCAN_COUNT_W-1:0] row,
        input int unsigned             hVisible,
        input int unsigned             vVisible
    );
        return (32'(column) >= hVisible) || (32'(row) >= vVisible);
    endfunction

endpackage

// File: rtl/vga_write_buffer_if.sv
// Bus bundle for the write buffer: CPU write side, VGA scan counters and video-RAM write port.
// master = CPU/VGA/RAM environment, slave = vga_write_buffer.
interface vga_write_buffer_if #(
    parameter int COLOR_W    = vga_wb_pkg::DEFAULT_COLOR_W,
    parameter int ADDR_W     = vga_wb_pkg::DEFAULT_ADDR_W,
    parameter int DEPTH_LOG2 = vga_wb_pkg::DEFAULT_DEPTH_LOG2
);

    logic                  iWriteEnable;
    logic [ADDR_W-1:0]     iWriteAddress;
    logic [COLOR_W-1:0]    iDataIn;
    logic [9:0]            iColumnCount;
    logic [9:0]            iRowCount;

    logic                  oFull;
    logic [DEPTH_LOG2:0]   oPending;
    logic                  oOverflow;
    logic                  oMemWriteEnable;
    logic [ADDR_W-1:0]     oMemWriteAddress;
    logic [COLOR_W-1:0]    oMemDataIn;

    modport master (
        output iWriteEnable, iWriteAddress, iDataIn, iColumnCount, iRowCount,
        input  oFull, oPending, oOverflow, oMemWriteEnable, oMemWriteAddress, oMemDataIn
    );

    modport slave (
        input  iWriteEnable, iWriteAddress, iDataIn, iColumnCount, iRowCount,
        output oFull, oPending, oOverflow, oMemWriteEnable, oMemWriteAddress, oMemDataIn
    );

endinterface

// File: rtl/vga_wb_fifo.sv
// Synchronous FIFO with async reset, plus an in-place update port aimed at the newest entry.
// The caller guarantees push only when not full (or popping) and pop only when not empty.
module vga_wb_fifo #(
    parameter int WIDTH      = 13,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      dataIn,
    output logic [WIDTH-1:0]      dataOut,
    input  logic                  update,
    input  logic [DEPTH_LOG2-1:0] updateIdx,
    input  logic [WIDTH-1:0]      updateData,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2-1:0] lastIdx
);

    localparam int                  DEPTH      = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] CNT_ONE    = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr;
    logic [DEPTH_LOG2-1:0] rdPtr;

    // NOTE: storage has no reset; an entry is only ever read after a push has written it,
    // and leaving it out keeps the array mappable to plain RAM/register-file cells.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wrPtr] <= dataIn;
        end else if (update) begin
            mem[updateIdx] <= updateData;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (push) wrPtr <= wrPtr + PTR_ONE;
            if (pop)  rdPtr <= rdPtr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    assign dataOut = mem[rdPtr];
    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign lastIdx = wrPtr - PTR_ONE;

endmodule

// File: rtl/vga_write_buffer.sv
// Posted-write buffer: queues CPU video-RAM writes and commits them only during VGA blanking.
// Define VGA_WB_COALESCE_EN to merge a write into the newest queued entry with the same address.
module vga_write_buffer
    import vga_wb_pkg::*;
#(
    parameter int          COLOR_W    = DEFAULT_COLOR_W,
    parameter int          ADDR_W     = DEFAULT_ADDR_W,
    parameter int          DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
    parameter int unsigned HVisible   = H_VISIBLE,
    parameter int unsigned VVisible   = V_VISIBLE
) (
    input logic               clk,
    input logic               rst,
    vga_write_buffer_if.slave bus
);

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [COLOR_W-1:0] colour;
    } entry_t;

    localparam logic [DEPTH_LOG2:0] CNT_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};

    wbState_t              state;
    wbState_t              nextState;
    logic                  blank;
    logic                  popNow;
    logic                  pushAccept;
    logic                  coalesce;
    logic                  overflowEvent;
    logic [DEPTH_LOG2:0]   count;
    logic [DEPTH_LOG2:0]   nextCount;
    logic                  fifoFull;
    logic                  fifoEmpty;
    logic [DEPTH_LOG2-1:0] lastIdx;
    entry_t                pushEntry;
    entry_t                headEntry;
    logic                  overflow;
    logic                  memWriteEnable;
    logic [ADDR_W-1:0]     memWriteAddress;
    logic [COLOR_W-1:0]    memDataIn;

    assign blank     = inBlanking(bus.iColumnCount, bus.iRowCount, HVisible, VVisible);
    assign pushEntry = '{addr: bus.iWriteAddress, colour: bus.iDataIn};

    // A pop in the same edge frees a slot, so a full FIFO still accepts the push.
    assign pushAccept    = bus.iWriteEnable && !coalesce && (!fifoFull || popNow);
    assign overflowEvent = bus.iWriteEnable && !coalesce && fifoFull && !popNow;
    assign nextCount     = count + {{DEPTH_LOG2{1'b0}}, pushAccept} - {{DEPTH_LOG2{1'b0}}, popNow};

`ifdef VGA_WB_COALESCE_EN
    logic [ADDR_W-1:0] lastAddr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lastAddr <= '0;
        end else if (pushAccept) begin
            lastAddr <= bus.iWriteAddress;
        end
    end

    // The newest entry is also the head when count is 1; if it leaves this edge, enqueue instead.
    assign coalesce = bus.iWriteEnable && !fifoEmpty && (bus.iWriteAddress == lastAddr)
                      && !(popNow && (count == CNT_ONE));
`else
    assign coalesce = 1'b0;
`endif

    vga_wb_fifo #(
        .WIDTH      ($bits(entry_t)),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (pushAccept),
        .pop        (popNow),
        .dataIn     (pushEntry),
        .dataOut    (headEntry),
        .update     (coalesce),
        .updateIdx  (lastIdx),
        .updateData (pushEntry),
        .count      (count),
        .full       (fifoFull),
        .empty      (fifoEmpty),
        .lastIdx    (lastIdx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // NOTE: the default assignment up front keeps every path assigned, so no latch is inferred.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (blank && !fifoEmpty) nextState = DRAIN;
            DRAIN:   if (!blank || (nextCount == '0)) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        popNow = (state == DRAIN) && blank && !fifoEmpty;
    end

    // Registered RAM port: address/data hold between pulses, enable is a one-cycle strobe per pop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            memWriteEnable  <= 1'b0;
            memWriteAddress <= '0;
            memDataIn       <= '0;
            overflow        <= 1'b0;
        end else begin
            memWriteEnable <= popNow;
            if (popNow) begin
                memWriteAddress <= headEntry.addr;
                memDataIn       <= headEntry.colour;
            end
            if (overflowEvent) begin
                overflow <= 1'b1;
            end
        end
    end

    assign bus.oFull            = fifoFull;
    assign bus.oPending         = count;
    assign bus.oOverflow        = overflow;
    assign bus.oMemWriteEnable  = memWriteEnable;
    assign bus.oMemWriteAddress = memWriteAddress;
    assign bus.oMemDataIn       = memDataIn;

endmodule

// File: tb/tb_vga_write_buffer.sv
// Self-checking bench for vga_write_buffer: directed scenarios plus randomized traffic
// compared against a queue-based reference model (honours VGA_WB_COALESCE_EN).
module tb_vga_write_buffer;
    import vga_wb_pkg::*;

`ifdef VGA_WB_COALESCE_EN
    localparam bit COALESCE = 1'b1;
`else
    localparam bit COALESCE = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    vga_write_buffer_if bus ();

    vga_write_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checkCount = 0;
    int passCount  = 0;

    // Reference model state
    wbEntry_t   modelQ[$];
    bit         modelDrain;
    bit         modelOvf;
    bit         modelWe;
    logic [9:0] modelAddr;
    logic [2:0] modelData;

    wbEntry_t   writes[$];

    task automatic modelClear();
        modelQ.delete();
        modelDrain = 1'b0;
        modelOvf   = 1'b0;
        modelWe    = 1'b0;
        modelAddr  = '0;
        modelData  = '0;
    endtask

    task automatic modelEdge(input logic we, input logic [9:0] addr, input logic [2:0] data,
                             input logic [9:0] col, input logic [9:0] row);
        bit       blankNow;
        int       sz;
        bit       pop;
        bit       merge;
        bit       doPush;
        wbEntry_t e;
        blankNow = (col >= 10'd640) || (row >= 10'd480);
        sz       = modelQ.size();
        pop      = modelDrain && blankNow && (sz > 0);
        merge    = COALESCE && we && (sz > 0) && (modelQ[sz-1].addr == addr) && !(pop && sz == 1);
        doPush   = 1'b0;
        modelWe  = pop;
        if (pop) begin
            modelAddr = modelQ[0].addr;
            modelData = modelQ[0].colour;
        end
        if (merge) begin
            e = modelQ[sz-1];
            e.colour = data;
            modelQ[sz-1] = e;
        end else if (we) begin
            if (sz < 8 || pop) doPush = 1'b1;
            else modelOvf = 1'b1;
        end
        if (pop) void'(modelQ.pop_front());
        if (doPush) modelQ.push_back('{addr: addr, colour: data});
        modelDrain = modelDrain ? (blankNow && modelQ.size() > 0) : (blankNow && sz > 0);
    endtask

    // Drive one cycle of inputs, take the edge, advance the model, log any RAM write.
    task automatic stepEdge(input logic we, input logic [9:0] addr, input logic [2:0] data,
                            input logic [9:0] col, input logic [9:0] row);
        bus.iWriteEnable  = we;
        bus.iWriteAddress = addr;
        bus.iDataIn       = data;
        bus.iColumnCount  = col;
        bus.iRowCount     = row;
        @(posedge clk);
        modelEdge(we, addr, data, col, row);
        #1;
        if (bus.oMemWriteEnable === 1'b1)
            writes.push_back('{addr: bus.oMemWriteAddress, colour: bus.oMemDataIn});
    endtask

    task automatic applyReset();
        bus.iWriteEnable = 1'b0;
        #2 rst = 1'b1;
        #4 rst = 1'b0;
        modelClear();
        writes.delete();
    endtask

    task automatic test_reset();
        int pulses;
        for (int i = 0; i < 9; i++) stepEdge(1'b1, 10'(i + 1), 3'b111, 10'd100, 10'd50);
        for (int i = 0; i < 3; i++) stepEdge(1'b0, 10'd0, 3'b000, 10'd700, 10'd50);
        checkCount++;
        if (bus.oMemWriteEnable !== 1'b1 || bus.oOverflow !== 1'b1)
            $display("FAIL pre_reset_activity: we=%b ovf=%b, required we=1 ovf=1", bus.oMemWriteEnable, bus.oOverflow);
        else passCount++;
        #2 rst = 1'b1;
        #1;
        checkCount++;
        if (bus.oMemWriteEnable !== 1'b0 || bus.oMemWriteAddress !== 10'd0 || bus.oMemDataIn !== 3'd0)
            $display("FAIL reset_mem_port: we=%b addr=%h data=%b, required 0/000/000", bus.oMemWriteEnable, bus.oMemWriteAddress, bus.oMemDataIn);
        else passCount++;
        checkCount++;
        if (bus.oPending !== 4'd0 || bus.oFull !== 1'b0 || bus.oOverflow !== 1'b0)
            $display("FAIL reset_status: pending=%0d full=%b ovf=%b, required 0/0/0", bus.oPending, bus.oFull, bus.oOverflow);
        else passCount++;
        #3 rst = 1'b0;
        modelClear();
        writes.delete();
        pulses = 0;
        for (int i = 0; i < 100; i++) begin
            stepEdge(1'b0, 10'd0, 3'b000, 10'd700, 10'd500);
            if (bus.oMemWriteEnable !== 1'b0) pulses++;
        end
        checkCount++;
        if (pulses != 0) $display("FAIL reset_idle_pulses: got %0d pulses, required 0", pulses);
        else passCount++;
    endtask

    task automatic test_visible_queue();
        applyReset();
        stepEdge(1'b1, 10'h005, 3'b101, 10'd100, 10'd50);
        checkCount++;
        if (bus.oPending !== 4'd1 || bus.oMemWriteEnable !== 1'b0)
            $display("FAIL visible_queue_hold: pending=%0d we=%b, required 1/0", bus.oPending, bus.oMemWriteEnable);
        else passCount++;
        stepEdge(1'b0, 10'd0, 3'b000, 10'd101, 10'd50);
        stepEdge(1'b0, 10'd0, 3'b000, 10'd640, 10'd50);
        checkCount++;
        if (bus.oMemWriteEnable !== 1'b0)
            $display("FAIL visible_queue_first_blank_edge: we=%b, required 0", bus.oMemWriteEnable);
        else passCount++;
        stepEdge(1'b0, 10'd0, 3'b000, 10'd641, 10'd50);
        checkCount++;
        if (bus.oMemWriteEnable !== 1'b1 || bus.oMemWriteAddress !== 10'h005 || bus.oMemDataIn !== 3'b101 || bus.oPending !== 4'd0)
            $display("FAIL visible_queue_write: we=%b addr=%h data=%b pending=%0d, required 1/005/101/0", bus.oMemWriteEnable, bus.oMemWriteAddress, bus.oMemDataIn, bus.oPending);
        else passCount++;
        for (int i = 0; i < 4; i++) stepEdge(1'b0, 10'd0, 3'b000, 10'd642, 10'd50);
        checkCount++;
        if (writes.size() != 1) $display("FAIL visible_queue_pulse_count: got %0d, required 1", writes.size());
        else passCount++;
    endtask

    task automatic test_fill_overflow();
        applyReset();
        for (int i = 0; i < 9; i++) begin
            stepEdge(1'b1, 10'(i), 3'(i), 10'd200, 10'd100);
            if (i == 6) begin
                checkCount++;
                if (bus.oFull !== 1'b0) $display("FAIL fill_not_full_at_7: full=%b, required 0", bus.oFull);
                else passCount++;
            end
            if (i == 7) begin
                checkCount++;
                if (bus.oFull !== 1'b1 || bus.oOverflow !== 1'b0)
                    $display("FAIL fill_full_at_8: full=%b ovf=%b, required 1/0", bus.oFull, bus.oOverflow);
                else passCount++;
            end
        end
        checkCount++;
        if (bus.oOverflow !== 1'b1 || bus.oPending !== 4'd8)
            $display("FAIL fill_overflow_at_9: ovf=%b pending=%0d, required 1/8", bus.oOverflow, bus.oPending);
        else passCount++;
        for (int i = 0; i < 14; i++) stepEdge(1'b0, 10'd0, 3'b000, 10'd300, 10'd490);
        checkCount++;
        if (writes.size() != 8) $display("FAIL fill_drain_count: got %0d writes, required 8", writes.size());
        else passCount++;
        for (int i = 0; i < 8; i++) begin
            checkCount++;
            if (i >= writes.size() || writes[i].addr !== 10'(i) || writes[i].colour !== 3'(i))
                $display("FAIL fill_drain_order[%0d]: got %h/%b, required %h/%b", i,
                         (i < writes.size()) ? writes[i].addr : 10'h3ff, (i < writes.size()) ? writes[i].colour : 3'b000, 10'(i), 3'(i));
            else passCount++;
        end
        checkCount++;
        if (bus.oOverflow !== 1'b1) $display("FAIL fill_overflow_sticky: ovf=%b, required 1", bus.oOverflow);
        else passCount++;
    endtask

    task automatic test_full_push_pop();
        applyReset();
        for (int i = 0; i < 8; i++) stepEdge(1'b1, 10'h100 + 10'(i), 3'b010, 10'd10, 10'd10);
        stepEdge(1'b0, 10'd0, 3'b000, 10'd650, 10'd10);
        checkCount++;
        if (bus.oFull !== 1'b1 || bus.oMemWriteEnable !== 1'b0)
            $display("FAIL full_pp_enter_drain: full=%b we=%b, required 1/0", bus.oFull, bus.oMemWriteEnable);
        else passCount++;
        stepEdge(1'b1, 10'h3ff, 3'b110, 10'd651, 10'd10);
        checkCount++;
        if (bus.oOverflow !== 1'b0 || bus.oPending !== 4'd8 || bus.oMemWriteEnable !== 1'b1)
            $display("FAIL full_pp_accept: ovf=%b pending=%0d we=%b, required 0/8/1", bus.oOverflow, bus.oPending, bus.oMemWriteEnable);
        else passCount++;
        for (int i = 0; i < 12; i++) stepEdge(1'b0, 10'd0, 3'b000, 10'd660, 10'd10);
        checkCount++;
        if (writes.size() != 9 || writes[writes.size()-1].addr !== 10'h3ff || writes[writes.size()-1].colour !== 3'b110)
            $display("FAIL full_pp_last_write: count=%0d last=%h, required 9 writes ending 3ff/110", writes.size(),
                     (writes.size() > 0) ? writes[writes.size()-1].addr : 10'h000);
        else passCount++;
    endtask

    task automatic test_drain_interrupted();
        applyReset();
        for (int i = 0; i < 8; i++) stepEdge(1'b1, 10'h020 + 10'(i), 3'(i), 10'd320, 10'd240);
        for (int i = 0; i < 3; i++) stepEdge(1'b0, 10'd0, 3'b000, 10'd700, 10'd240);
        for (int i = 0; i < 4; i++) stepEdge(1'b0, 10'd0, 3'b000, 10'd5, 10'd241);
        checkCount++;
        if (writes.size() != 2 || bus.oPending !== 4'd6)
            $display("FAIL drain_int_partial: writes=%0d pending=%0d, required 2/6", writes.size(), bus.oPending);
        else passCount++;
        for (int i = 0; i < 10; i++) stepEdge(1'b0, 10'd0, 3'b000, 10'd100, 10'd479 + 10'd1);
        checkCount++;
        if (writes.size() != 8) $display("FAIL drain_int_total: got %0d writes, required 8", writes.size());
        else passCount++;
        for (int i = 0; i < 8; i++) begin
            checkCount++;
            if (i >= writes.size() || writes[i].addr !== 10'h020 + 10'(i))
                $display("FAIL drain_int_order[%0d]: got %h, required %h", i,
                         (i < writes.size()) ? writes[i].addr : 10'h3ff, 10'h020 + 10'(i));
            else passCount++;
        end
    endtask

    task automatic test_coalesce();
        int expPending;
        applyReset();
        expPending = COALESCE ? 1 : 2;
        stepEdge(1'b1, 10'h010, 3'd1, 10'd50, 10'd50);
        stepEdge(1'b1, 10'h010, 3'd6, 10'd51, 10'd50);
        checkCount++;
        if (int'(bus.oPending) != expPending)
            $display("FAIL coalesce_pending: got %0d, required %0d", bus.oPending, expPending);
        else passCount++;
        for (int i = 0; i < 8; i++) stepEdge(1'b0, 10'd0, 3'b000, 10'd700, 10'd50);
        checkCount++;
        if (writes.size() != expPending) $display("FAIL coalesce_write_count: got %0d, required %0d", writes.size(), expPending);
        else passCount++;
        checkCount++;
        if (writes.size() == 0 || writes[writes.size()-1].colour !== 3'd6 || (!COALESCE && writes[0].colour !== 3'd1))
            $display("FAIL coalesce_colours: first=%b last=%b", (writes.size() > 0) ? writes[0].colour : 3'b000,
                     (writes.size() > 0) ? writes[writes.size()-1].colour : 3'b000);
        else passCount++;
    endtask

    task automatic test_random();
        bit         blankRegion;
        bit         bad;
        int         failPrints;
        logic       we;
        logic [9:0] addr;
        logic [2:0] data;
        logic [9:0] col;
        logic [9:0] row;
        applyReset();
        blankRegion = 1'b0;
        failPrints  = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ($urandom_range(0, 499) == 0) applyReset();
            if ($urandom_range(0, 5) == 0) blankRegion = ~blankRegion;
            we   = ($urandom_range(0, 99) < 45);
            addr = 10'h0c0 + 10'($urandom_range(0, 3));
            data = 3'($urandom);
            if (blankRegion) begin
                col = 10'($urandom_range(640, 799));
                row = 10'($urandom_range(0, 524));
            end else begin
                col = 10'($urandom_range(0, 639));
                row = 10'($urandom_range(0, 479));
            end
            stepEdge(we, addr, data, col, row);
            bad = (bus.oMemWriteEnable !== modelWe) || (bus.oMemWriteAddress !== modelAddr) ||
                  (bus.oMemDataIn !== modelData) || (int'(bus.oPending) != modelQ.size()) ||
                  (bus.oFull !== (modelQ.size() == 8)) || (bus.oOverflow !== modelOvf);
            checkCount++;
            if (bad) begin
                if (failPrints < 10)
                    $display("FAIL random_cycle_%0d: we=%b addr=%h data=%b pend=%0d full=%b ovf=%b, required we=%b addr=%h data=%b pend=%0d ovf=%b",
                             cyc, bus.oMemWriteEnable, bus.oMemWriteAddress, bus.oMemDataIn, bus.oPending, bus.oFull, bus.oOverflow,
                             modelWe, modelAddr, modelData, modelQ.size(), modelOvf);
                failPrints++;
            end else passCount++;
        end
    endtask

    initial begin
        rst               = 1'b1;
        bus.iWriteEnable  = 1'b0;
        bus.iWriteAddress = '0;
        bus.iDataIn       = '0;
        bus.iColumnCount  = '0;
        bus.iRowCount     = '0;
        modelClear();
        #12 rst = 1'b0;
        test_reset();
        test_visible_queue();
        test_fill_overflow();
        test_full_push_pop();
        test_drain_interrupted();
        test_coalesce();
        test_random();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
